// File: rtl/mux_bus_arbiter.sv
// Two-requester valid/ready arbiter steering a WIDTH-bit 2:1 word mux into a
// one-entry registered output stage. Round-robin or fixed-priority grant.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | output register holds no word (out_valid=0)
// FULL  | output register holds a word awaiting out_ready (out_valid=1)
module mux_bus_arbiter #(
    parameter int WIDTH       = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             last;
    logic             sel_q;
    logic             load;
    logic             any_req;
    logic             take;
    logic             grant;
    logic [WIDTH-1:0] mux_word;

    // Without a capture the select line parks on its previous value so the
    // mux never toggles while idle or stalled.
    always_comb begin
        load    = (state == EMPTY) | out_ready;
        any_req = in0_valid | in1_valid;
        take    = load & ~rst & any_req;
        grant   = sel_q;
        if (take) begin
            if (in0_valid && in1_valid) begin
                grant = ROUND_ROBIN ? ~last : 1'b0;
            end else begin
                grant = in1_valid;
            end
        end
    end

    assign select    = grant;
    assign in0_ready = take & in0_valid & ~grant;
    assign in1_ready = take & in1_valid & grant;
    assign mux_word  = grant ? in1_data : in0_data;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= 1'b0;
            last     <= 1'b1;
            sel_q    <= 1'b0;
        end else begin
            sel_q <= grant;
            if (take) begin
                state    <= FULL;
                out_data <= mux_word;
                out_src  <= grant;
                last     <= grant;
            end else if (load) begin
                state <= EMPTY;
            end
        end
    end

endmodule
